// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// State advances on the falling clock edge, matching the surrounding pipeline registers.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             StartE,
  input  logic [2:0]       MulDivOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic             BusyE,
  output logic             DoneE,
  output logic [WIDTH-1:0] ResultE
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} stateT;

  stateT              stateQ, stateD;
  logic [CntW-1:0]    cntQ, cntD;
  logic [2*WIDTH-1:0] accQ, accD;
  logic [WIDTH-1:0]   opndQ, opndD;
  logic [2:0]         opQ, opD;
  logic               negResQ, negResD;
  logic               negRemQ, negRemD;
  logic [WIDTH-1:0]   resultQ, resultD;

  logic             aSigned, bSigned, signA, signB, isDiv, divZero, divOvf;
  logic [WIDTH-1:0] magA, magB, specialRes;

  // Issue-time decode: operand magnitudes, sign flags and divide corner cases.
  always_comb begin
    isDiv   = MulDivOpE[2];
    aSigned = MulDivOpE inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
    bSigned = MulDivOpE inside {3'b000, 3'b001, 3'b100, 3'b110};
    signA   = aSigned & SrcAE[WIDTH-1];
    signB   = bSigned & SrcBE[WIDTH-1];
    magA    = signA ? -SrcAE : SrcAE;
    magB    = signB ? -SrcBE : SrcBE;
    divZero = isDiv & (SrcBE == '0);
    divOvf  = isDiv & ~MulDivOpE[0] & (SrcAE == {1'b1, {(WIDTH-1){1'b0}}}) & (SrcBE == '1);
    if (divZero) begin
      specialRes = MulDivOpE[1] ? SrcAE : '1;
    end else begin
      specialRes = MulDivOpE[1] ? '0 : SrcAE;
    end
  end

  logic [WIDTH:0]     mulSum, remSh, remDiff;
  logic [2*WIDTH-1:0] accStep, prodSigned;
  logic [WIDTH-1:0]   quot, rem, finalRes;

  // One iteration; the final result is taken from the post-step accumulator.
  always_comb begin
    mulSum  = {1'b0, accQ[2*WIDTH-1:WIDTH]} + (accQ[0] ? {1'b0, opndQ} : '0);
    remSh   = accQ[2*WIDTH-1:WIDTH-1];
    remDiff = remSh - {1'b0, opndQ};
    if (!opQ[2]) begin
      accStep = {mulSum, accQ[WIDTH-1:1]};
    end else if (!remDiff[WIDTH]) begin
      accStep = {remDiff[WIDTH-1:0], accQ[WIDTH-2:0], 1'b1};
    end else begin
      accStep = {remSh[WIDTH-1:0], accQ[WIDTH-2:0], 1'b0};
    end
    prodSigned = negResQ ? -accStep : accStep;
    quot       = negResQ ? -accStep[WIDTH-1:0] : accStep[WIDTH-1:0];
    rem        = negRemQ ? -accStep[2*WIDTH-1:WIDTH] : accStep[2*WIDTH-1:WIDTH];
    if (!opQ[2]) begin
      finalRes = (opQ[1:0] == 2'b00) ? prodSigned[WIDTH-1:0] : prodSigned[2*WIDTH-1:WIDTH];
    end else begin
      finalRes = opQ[1] ? rem : quot;
    end
  end

  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    accD    = accQ;
    opndD   = opndQ;
    opD     = opQ;
    negResD = negResQ;
    negRemD = negRemQ;
    resultD = resultQ;
    case (stateQ)
      StIdle: begin
        if (StartE && !clear) begin
          opD     = MulDivOpE;
          negResD = signA ^ signB;
          negRemD = signA;
          opndD   = isDiv ? magB : magA;
          accD    = {{WIDTH{1'b0}}, (isDiv ? magA : magB)};
          if (divZero || divOvf) begin
            resultD = specialRes;
            stateD  = StDone;
          end else begin
            cntD   = CntW'(WIDTH - 1);
            stateD = StRun;
          end
        end
      end
      StRun: begin
        if (clear) begin
          stateD = StIdle;
        end else begin
          accD = accStep;
          if (cntQ == '0) begin
            resultD = finalRes;
            stateD  = StDone;
          end else begin
            cntD = cntQ - 1'b1;
          end
        end
      end
      StDone: stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      stateQ  <= StIdle;
      cntQ    <= '0;
      accQ    <= '0;
      opndQ   <= '0;
      opQ     <= '0;
      negResQ <= 1'b0;
      negRemQ <= 1'b0;
      resultQ <= '0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      accQ    <= accD;
      opndQ   <= opndD;
      opQ     <= opD;
      negResQ <= negResD;
      negRemQ <= negRemD;
      resultQ <= resultD;
    end
  end

  assign BusyE   = (stateQ == StRun) | ((stateQ == StIdle) & StartE & ~clear);
  assign DoneE   = (stateQ == StDone) & ~clear;
  assign ResultE = resultQ;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: cycle-accurate busy/done timing and RV32M results.
// Inputs change just after the falling (active) edge; outputs are sampled on the rising edge.
module tb_ex_muldiv_unit;
  logic        clk;
  logic        reset;
  logic        clear;
  logic        StartE;
  logic [2:0]  MulDivOpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        BusyE;
  logic        DoneE;
  logic [31:0] ResultE;

  int checks   = 0;
  int failures = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .StartE    (StartE),
    .MulDivOpE (MulDivOpE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .BusyE     (BusyE),
    .DoneE     (DoneE),
    .ResultE   (ResultE)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  // Issue one op with StartE held through DONE, then check timing and result.
  task automatic doOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int expDone);
    int doneCnt = 0;
    int doneAt  = -1;
    int busyErr = 0;
    logic [31:0] res = '0;
    StartE    = 1'b1;
    MulDivOpE = op;
    SrcAE     = a;
    SrcBE     = b;
    for (int c = 0; c <= expDone + 2; c++) begin
      @(posedge clk);
      if (BusyE !== (c < expDone)) busyErr++;
      if (DoneE === 1'b1) begin
        doneCnt++;
        if (doneAt < 0) begin
          doneAt = c;
          res    = ResultE;
        end
      end
      nextCycle();
      if (c == expDone) StartE = 1'b0;
    end
    checkVal({tag, " done_count"}, doneCnt, 1);
    checkVal({tag, " done_cycle"}, doneAt, expDone);
    checkVal({tag, " busy_errors"}, busyErr, 0);
    checkVal({tag, " result"}, res, exp);
    checkVal({tag, " result_hold"}, ResultE, exp);
  endtask

  initial begin
    int doneSeen;
    reset     = 1'b0;
    clear     = 1'b0;
    StartE    = 1'b0;
    MulDivOpE = '0;
    SrcAE     = '0;
    SrcBE     = '0;
    #2;
    checkVal("reset busy", BusyE, 0);
    checkVal("reset done", DoneE, 0);
    checkVal("reset result", ResultE, 0);
    nextCycle();
    reset = 1'b1;
    nextCycle();

    doOp("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);

    // Reset in cycle 10 of a MUL must clear outputs at once and leave no DoneE behind.
    StartE    = 1'b1;
    MulDivOpE = 3'b000;
    SrcAE     = 32'd7;
    SrcBE     = 32'd5;
    for (int c = 0; c < 10; c++) nextCycle();
    reset  = 1'b0;
    StartE = 1'b0;
    #1;
    checkVal("midreset busy", BusyE, 0);
    checkVal("midreset done", DoneE, 0);
    checkVal("midreset result", ResultE, 0);
    nextCycle();
    reset    = 1'b1;
    doneSeen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      if (DoneE === 1'b1) doneSeen++;
      nextCycle();
    end
    checkVal("midreset no_done", doneSeen, 0);

    doOp("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    doOp("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    doOp("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
    doOp("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    doOp("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    doOp("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    doOp("REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    doOp("DIVU 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    doOp("REM 5/0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    doOp("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    doOp("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Flush in cycle 12 of a divide: back to idle on the next edge with no DoneE.
    StartE    = 1'b1;
    MulDivOpE = 3'b101;
    SrcAE     = 32'd100;
    SrcBE     = 32'd7;
    for (int c = 0; c < 12; c++) nextCycle();
    clear = 1'b1;
    @(posedge clk);
    checkVal("clear cycle busy", BusyE, 1);
    nextCycle();
    clear  = 1'b0;
    StartE = 1'b0;
    @(posedge clk);
    checkVal("after clear busy", BusyE, 0);
    nextCycle();
    doneSeen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      if (DoneE === 1'b1) doneSeen++;
      nextCycle();
    end
    checkVal("after clear no_done", doneSeen, 0);

    doOp("MUL 3*4", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative integer multiply/divide unit for the RV32M instructions, sitting in the Execute stage directly downstream of the ID/EX control pipeline register. It takes the operation and operands of the instruction currently in Execute and holds the pipeline busy while it runs. It returns a single result word on a one-cycle done pulse, which the EX/MEM register then captures. Multiply and divide both use one shift-add/shift-subtract step per cycle.

## Interface
- WIDTH, 32, operand and result width (XLEN).
- clk  in  1  pipeline clock; all state updates on the falling edge, like every other pipeline register.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush from the hazard unit; aborts any operation in progress.
- StartE  in  1  the instruction in Execute is an M-extension op.
- MulDivOpE  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcAE  in  WIDTH  operand rs1 (multiplicand/dividend).
- SrcBE  in  WIDTH  operand rs2 (multiplier/divisor).
- BusyE  out  1  stall request to the hazard unit (hold F/D/E).
- DoneE  out  1  ResultE valid this cycle.
- ResultE  out  WIDTH  result.

## Operation
- States are IDLE, RUN and DONE. The iteration counter is $clog2(WIDTH) bits.
- IDLE:
  - If StartE=1 and clear=0 at the edge, latch operand magnitudes, result-sign flags, op and special-case flags.
  - Normally go to RUN with the counter at WIDTH-1.
  - For the divide special cases below, go straight to DONE.
- RUN:
  - Each edge performs one step.
  - MUL step: 2·WIDTH-bit shift-add accumulator.
  - DIV step: restoring shift-subtract, with the remainder in the upper half and the quotient in the lower half.
  - When the counter reaches 0, go to DONE and load ResultE.
- DONE: DoneE=1 for exactly one cycle, then unconditionally back to IDLE. StartE is ignored in DONE, because the same instruction is still presented.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - Magnitudes are computed at latch time.
  - Product sign = sA^sB.
  - Quotient sign = sA^sB.
  - Remainder sign = sA.
  - Negation is applied when ResultE is loaded.
- Result selection:
  - MUL: low WIDTH bits.
  - MULH*: high WIDTH bits.
  - DIV*: quotient.
  - REM*: remainder.
- Special cases (RISC-V semantics, no trap):
  - Divisor = 0: quotient all ones; remainder = SrcAE unmodified.
  - Signed overflow (DIV/REM, A=100…0, B=all ones): quotient = A; remainder = 0.
- BusyE = (state==RUN) | (state==IDLE & StartE & ~clear). It is combinational, so the issue cycle is already stalled. BusyE=0 in DONE, so the pipeline advances on the DONE edge.
- ResultE holds its last value outside DONE.
- clear in RUN or DONE returns the unit to IDLE at the next edge and suppresses DoneE. clear has priority over StartE.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, BusyE=0, DoneE=0, ResultE=0, counter=0, accumulators=0.
- Cycle numbering: cycle 0 is the cycle in which StartE is first seen in IDLE.
- Normal path:
  - RUN occupies cycles 1..WIDTH.
  - DONE is cycle WIDTH+1, so 34 cycles for WIDTH=32.
  - BusyE is high in cycles 0..WIDTH.
- Special-case divide: DONE in cycle 1 and BusyE high only in cycle 0.
- Back-to-back M ops: the next StartE is accepted in the cycle after DONE.
- Reset asserted mid-RUN clears immediately; no DoneE follows.

## Test plan
- Reset mid-operation: start MUL, drive reset=0 in cycle 10 → BusyE, DoneE and ResultE go to 0 immediately; no DoneE after reset is released.
- MUL 7 × 0xFFFFFFFD (−3) → DoneE in cycle 33 only, ResultE=0xFFFFFFEB; BusyE high in cycles 0–32.
- High-half multiplies:
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- Special cases, each with DoneE in cycle 1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- Flush and DONE behaviour:
  - clear=1 in cycle 12 of a DIV → IDLE next edge, no DoneE, BusyE drops.
  - A new MUL 3×4 issued afterwards → ResultE=12.
  - StartE held high through DONE does not restart the unit.
